// File: rtl/alu_pipe.sv
// Pipelined integer ALU: computes in stage 1 and delays through STAGES-1 further registers.
// The whole pipe freezes while a result waits unread at the output; flush and reset drop all in-flight ops.
module alu_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned ROB_IX = 2,
  parameter int unsigned STAGES = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              flush_in,
  input  logic              valid_in,
  output logic              ready_out,
  input  logic [WIDTH-1:0]  rval1_in,
  input  logic [WIDTH-1:0]  rval2_in,
  input  logic [3:0]        aluFunc_in,
  input  logic [ROB_IX:0]   rob_ix_in,
  output logic              valid_out,
  input  logic              read_in,
  output logic [WIDTH-1:0]  data_out,
  output logic [ROB_IX:0]   rob_ix_out
);

  localparam int unsigned TAG_W = ROB_IX + 1;
  localparam int unsigned SH_W  = $clog2(WIDTH);

  typedef enum logic [3:0] {
    FN_ADD  = 4'd0,
    FN_SUB  = 4'd1,
    FN_AND  = 4'd2,
    FN_OR   = 4'd3,
    FN_XOR  = 4'd4,
    FN_SLT  = 4'd5,
    FN_SLTU = 4'd6,
    FN_SLL  = 4'd7,
    FN_SRL  = 4'd8,
    FN_SRA  = 4'd9
  } alu_func_e;

  logic             valid_q [STAGES];
  logic [WIDTH-1:0] data_q  [STAGES];
  logic [TAG_W-1:0] tag_q   [STAGES];

  logic [WIDTH-1:0] res_d;
  logic [SH_W-1:0]  shamt;
  logic             stall;
  logic             accept;

  // Output stage holds an unread result: freeze everything behind it.
  assign stall     = valid_q[STAGES-1] && !read_in;
  assign ready_out = !rst_in && !stall;
  assign accept    = valid_in && ready_out && !flush_in;
  assign shamt     = rval2_in[SH_W-1:0];

  // Stage-1 result; unassigned codes complete with zero.
  always_comb begin
    res_d = '0;
    case (alu_func_e'(aluFunc_in))
      FN_ADD:  res_d = rval1_in + rval2_in;
      FN_SUB:  res_d = rval1_in - rval2_in;
      FN_AND:  res_d = rval1_in & rval2_in;
      FN_OR:   res_d = rval1_in | rval2_in;
      FN_XOR:  res_d = rval1_in ^ rval2_in;
      FN_SLT:  res_d = WIDTH'($signed(rval1_in) < $signed(rval2_in));
      FN_SLTU: res_d = WIDTH'(rval1_in < rval2_in);
      FN_SLL:  res_d = rval1_in << shamt;
      FN_SRL:  res_d = rval1_in >> shamt;
      FN_SRA:  res_d = WIDTH'($unsigned($signed(rval1_in) >>> shamt));
      default: res_d = '0;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        valid_q[i] <= 1'b0;
        data_q[i]  <= '0;
        tag_q[i]   <= '0;
      end
    end else if (flush_in) begin
      for (int i = 0; i < int'(STAGES); i++) begin
        valid_q[i] <= 1'b0;
      end
    end else if (!stall) begin
      valid_q[0] <= accept;
      data_q[0]  <= res_d;
      tag_q[0]   <= rob_ix_in;
      for (int i = 1; i < int'(STAGES); i++) begin
        valid_q[i] <= valid_q[i-1];
        data_q[i]  <= data_q[i-1];
        tag_q[i]   <= tag_q[i-1];
      end
    end
  end

  assign valid_out  = valid_q[STAGES-1];
  assign data_out   = data_q[STAGES-1];
  assign rob_ix_out = tag_q[STAGES-1];

endmodule

// File: tb/tb_alu_pipe.sv
// Bench for alu_pipe: queue-based latency/ordering model checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_alu_pipe;

  localparam int W  = 32;
  localparam int RI = 2;
  localparam int ST = 2;
  localparam int TW = RI + 1;

  logic          clk;
  logic          rst_in, flush_in, valid_in, read_in;
  logic          ready_out, valid_out;
  logic [W-1:0]  rval1_in, rval2_in, data_out;
  logic [3:0]    aluFunc_in;
  logic [TW-1:0] rob_ix_in, rob_ix_out;

  alu_pipe #(.WIDTH(W), .ROB_IX(RI), .STAGES(ST)) dut (
    .clk_in     (clk),
    .rst_in     (rst_in),
    .flush_in   (flush_in),
    .valid_in   (valid_in),
    .ready_out  (ready_out),
    .rval1_in   (rval1_in),
    .rval2_in   (rval2_in),
    .aluFunc_in (aluFunc_in),
    .rob_ix_in  (rob_ix_in),
    .valid_out  (valid_out),
    .read_in    (read_in),
    .data_out   (data_out),
    .rob_ix_out (rob_ix_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  bit chk_en = 1'b0;

  // In-flight ops: result, tag, and number of advancing edges seen since accept.
  logic [W-1:0]  m_data[$];
  logic [TW-1:0] m_tag[$];
  int            m_cnt[$];

  // Results actually delivered by the DUT, with the cycle they were taken.
  logic [W-1:0]  l_data[$];
  logic [TW-1:0] l_tag[$];
  int            l_cyc[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] ref_alu(input logic [3:0] f, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
    int s;
    s = int'(b[4:0]);
    case (f)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ((a[W-1] && !b[W-1]) || (a[W-1] == b[W-1] && a < b)) ? 1 : 0;
      4'd6: return (a < b) ? 1 : 0;
      4'd7: return a << s;
      4'd8: return a >> s;
      4'd9: return (a >> s) | (a[W-1] ? ~(32'hFFFF_FFFF >> s) : 32'h0);
      default: return '0;
    endcase
  endfunction

  function automatic bit model_valid();
    return (m_cnt.size() > 0) && (m_cnt[0] >= ST);
  endfunction

  // Model update on each rising edge from the inputs held across it.
  initial begin
    bit ev, stl;
    forever begin
      @(posedge clk);
      if (rst_in) begin
        m_data.delete(); m_tag.delete(); m_cnt.delete();
      end else begin
        ev  = model_valid();
        stl = ev && !read_in;
        if (flush_in) begin
          m_data.delete(); m_tag.delete(); m_cnt.delete();
        end else if (!stl) begin
          if (ev && read_in) begin
            void'(m_data.pop_front()); void'(m_tag.pop_front()); void'(m_cnt.pop_front());
          end
          for (int i = 0; i < m_cnt.size(); i++) m_cnt[i] = m_cnt[i] + 1;
          if (valid_in) begin
            m_data.push_back(ref_alu(aluFunc_in, rval1_in, rval2_in));
            m_tag.push_back(rob_ix_in);
            m_cnt.push_back(1);
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, mid-cycle.
  initial begin
    bit ev, er;
    forever begin
      @(negedge clk);
      cyc++;
      if (chk_en) begin
        ev = model_valid();
        er = !rst_in && !(ev && !read_in);
        chk("valid_out", 64'(valid_out), 64'(ev));
        chk("ready_out", 64'(ready_out), 64'(er));
        if (ev) begin
          chk("data_out", 64'(data_out), 64'(m_data[0]));
          chk("rob_ix_out", 64'(rob_ix_out), 64'(m_tag[0]));
        end
        if (valid_out === 1'b1 && read_in) begin
          l_data.push_back(data_out);
          l_tag.push_back(rob_ix_out);
          l_cyc.push_back(cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Present one op and hold it until the handshake completes.
  task automatic send(input logic [3:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [TW-1:0] t);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    valid_in = 1'b1; aluFunc_in = f; rval1_in = a; rval2_in = b; rob_ix_in = t;
    while (!done) begin
      @(negedge clk);
      done = ready_out && !flush_in;
      @(posedge clk);
      #2;
      n++;
      if (!done && n > 50) begin
        chk("send_timeout", 64'(n), 64'(0));
        done = 1'b1;
      end
    end
    valid_in = 1'b0;
  endtask

  task automatic wait_log(input int n);
    for (int i = 0; i < 60; i++) begin
      if (l_data.size() >= n) break;
      step();
    end
    chk("log_count", 64'(l_data.size()), 64'(n));
  endtask

  task automatic chk_log(input int i, input logic [W-1:0] d, input logic [TW-1:0] t);
    if (i < l_data.size()) begin
      chk("log_data", 64'(l_data[i]), 64'(d));
      chk("log_tag", 64'(l_tag[i]), 64'(t));
    end else begin
      chk("log_missing", 64'(l_data.size()), 64'(i + 1));
    end
  endtask

  initial begin
    int base;
    rst_in = 1'b1; flush_in = 1'b0; valid_in = 1'b0; read_in = 1'b1;
    rval1_in = '0; rval2_in = '0; aluFunc_in = '0; rob_ix_in = '0;

    // Reset
    step(); chk_en = 1'b1; step(); step();
    @(negedge clk);
    chk("rst_valid", 64'(valid_out), 64'(0));
    chk("rst_data", 64'(data_out), 64'(0));
    chk("rst_tag", 64'(rob_ix_out), 64'(0));
    chk("rst_ready", 64'(ready_out), 64'(0));
    step();
    rst_in = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(ready_out), 64'(1));
    step();

    // Back-to-back stream
    send(4'd0, 32'd5, 32'd7, 3'd1);
    send(4'd1, 32'd3, 32'd5, 3'd2);
    wait_log(2);
    chk_log(0, 32'd12, 3'd1);
    chk_log(1, 32'hFFFF_FFFE, 3'd2);
    if (l_cyc.size() >= 2) chk("b2b_gap", 64'(l_cyc[1] - l_cyc[0]), 64'(1));

    // Shifts, compares, unassigned code
    send(4'd9, 32'h8000_0000, 32'd33, 3'd3);
    send(4'd8, 32'h8000_0000, 32'd4, 3'd4);
    send(4'd7, 32'd1, 32'd31, 3'd5);
    send(4'd5, 32'hFFFF_FFFF, 32'd1, 3'd6);
    send(4'd6, 32'hFFFF_FFFF, 32'd1, 3'd7);
    send(4'd12, 32'd9, 32'd9, 3'd5);
    wait_log(8);
    chk_log(2, 32'hC000_0000, 3'd3);
    chk_log(3, 32'h0800_0000, 3'd4);
    chk_log(4, 32'h8000_0000, 3'd5);
    chk_log(5, 32'd1, 3'd6);
    chk_log(6, 32'd0, 3'd7);
    chk_log(7, 32'd0, 3'd5);

    // Back-pressure
    read_in = 1'b0;
    base = l_data.size();
    send(4'd0, 32'd1, 32'd1, 3'd1);
    send(4'd0, 32'd2, 32'd2, 3'd2);
    fork
      send(4'd0, 32'd3, 32'd3, 3'd3);
    join_none
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_ready", 64'(ready_out), 64'(0));
      chk("bp_valid", 64'(valid_out), 64'(1));
      chk("bp_data", 64'(data_out), 64'(2));
      chk("bp_tag", 64'(rob_ix_out), 64'(1));
      step();
    end
    read_in = 1'b1;
    wait fork;
    wait_log(base + 3);
    chk_log(base, 32'd2, 3'd1);
    chk_log(base + 1, 32'd4, 3'd2);
    chk_log(base + 2, 32'd6, 3'd3);
    if (l_cyc.size() >= base + 3) begin
      chk("bp_gap1", 64'(l_cyc[base+1] - l_cyc[base]), 64'(1));
      chk("bp_gap2", 64'(l_cyc[base+2] - l_cyc[base+1]), 64'(1));
    end

    // Flush with two ops in flight and one presented
    read_in = 1'b0;
    base = l_data.size();
    send(4'd4, 32'hF0, 32'hFF, 3'd1);
    send(4'd3, 32'h10, 32'h01, 3'd2);
    valid_in = 1'b1; aluFunc_in = 4'd0; rval1_in = 32'd8; rval2_in = 32'd8; rob_ix_in = 3'd3;
    flush_in = 1'b1;
    step();
    flush_in = 1'b0; valid_in = 1'b0; read_in = 1'b1;
    @(negedge clk);
    chk("flush_valid", 64'(valid_out), 64'(0));
    step();
    send(4'd1, 32'd10, 32'd3, 3'd6);
    @(negedge clk);
    chk("flush_lat_early", 64'(valid_out), 64'(0));
    step();
    @(negedge clk);
    chk("flush_lat_valid", 64'(valid_out), 64'(1));
    chk("flush_lat_data", 64'(data_out), 64'(7));
    chk("flush_lat_tag", 64'(rob_ix_out), 64'(6));
    step(); step(); step();
    chk("flush_count", 64'(l_data.size()), 64'(base + 1));
    chk_log(base, 32'd7, 3'd6);

    // Reset with a full, stalled pipeline
    read_in = 1'b0;
    base = l_data.size();
    send(4'd0, 32'd100, 32'd1, 3'd1);
    send(4'd0, 32'd200, 32'd1, 3'd2);
    valid_in = 1'b1; rval1_in = 32'd300; rob_ix_in = 3'd3;
    rst_in = 1'b1;
    step();
    valid_in = 1'b0;
    @(negedge clk);
    chk("mid_rst_valid", 64'(valid_out), 64'(0));
    chk("mid_rst_data", 64'(data_out), 64'(0));
    chk("mid_rst_tag", 64'(rob_ix_out), 64'(0));
    chk("mid_rst_ready", 64'(ready_out), 64'(0));
    step();
    rst_in = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready_after", 64'(ready_out), 64'(1));
    read_in = 1'b1;
    step(); step(); step(); step();
    chk("mid_rst_nothing_out", 64'(l_data.size()), 64'(base));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
